// File: rtl/if_fetch_unit_if.sv
// Signal bundle between the IF fetch unit, the instruction memory and the
// IF/ID register. The fetch unit takes the master side; the surrounding
// pipeline/memory environment takes the slave side.
interface if_fetch_unit_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  // instruction memory port
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  imem_addr_valid;
  // control-flow redirect from later stages
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  // IF/ID handshake
  logic                  id_ready;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [31:0]           if_pc;
  logic                  if_fault;

  modport master (
    output imem_addr,
    input  imem_data,
    input  imem_addr_valid,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output if_valid,
    output if_instr,
    output if_pc,
    output if_fault
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output imem_addr_valid,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  if_fault
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine. Owns the PC, drives the IMEM word address every
// cycle, tracks the fixed 2-cycle IMEM latency with a 2-stage tag pipeline and
// buffers returned instructions in a FIFO_DEPTH-entry FIFO feeding the IF/ID
// valid/ready handshake. A redirect flushes both the FIFO and in-flight tags.
// Optional performance counters are built when IF_PERF_CNT_EN is defined;
// otherwise perf_fetched/perf_stall are tied to zero.
module if_fetch_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  if_fetch_unit_if.master bus,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

  // A fetch faults when IMEM flags the address or the PC lies above the IMEM window.
  function automatic logic fetch_fault(input logic [31:0] pc, input logic range_ok);
    return !range_ok || ((pc >> (ADDR_WIDTH + 2)) != 32'd0);
  endfunction

  // PC and in-flight tag pipeline (stage 1 = issued last cycle, stage 2 = data arriving now)
  logic [31:0] pc_r;
  logic        s1_valid_r;
  logic [31:0] s1_pc_r;
  logic        s2_valid_r;
  logic [31:0] s2_pc_r;

  // instruction buffer
  logic [DATA_WIDTH-1:0] fifo_instr_r [FIFO_DEPTH];
  logic [31:0]           fifo_pc_r    [FIFO_DEPTH];
  logic                  fifo_fault_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  logic [OCC_W-1:0]      occupancy_s;
  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  if_valid_s;
  logic                  push_fault_s;
  logic [DATA_WIDTH-1:0] push_instr_s;
  logic [31:0]           redirect_target_s;

  assign redirect_target_s = bus.redirect_pc & 32'hFFFF_FFFC;
  assign bus.imem_addr     = pc_r[ADDR_WIDTH+1:2];

  // Credit check, push/pop decisions and the data captured on a response
  always_comb begin
    occupancy_s  = {1'b0, count_r} + OCC_W'(s1_valid_r) + OCC_W'(s2_valid_r);
    issue_s      = (occupancy_s < OCC_W'(FIFO_DEPTH)) && !bus.redirect_valid;
    push_s       = s2_valid_r && !bus.redirect_valid;
    if_valid_s   = (count_r != {CNT_W{1'b0}}) && !bus.redirect_valid;
    pop_s        = if_valid_s && bus.id_ready;
    push_fault_s = fetch_fault(s2_pc_r, bus.imem_addr_valid);
    if (push_fault_s) begin
      push_instr_s = NOP_INSTR;
    end else begin
      push_instr_s = bus.imem_data;
    end
  end

  // Head-of-FIFO presentation; zeros whenever nothing is offered
  always_comb begin
    bus.if_valid = if_valid_s;
    if (if_valid_s) begin
      bus.if_instr = fifo_instr_r[rd_ptr_r];
      bus.if_pc    = fifo_pc_r[rd_ptr_r];
      bus.if_fault = fifo_fault_r[rd_ptr_r];
    end else begin
      bus.if_instr = {DATA_WIDTH{1'b0}};
      bus.if_pc    = 32'd0;
      bus.if_fault = 1'b0;
    end
  end

  // PC advance and latency-tracking tags; redirect reloads PC and kills all tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      s1_valid_r <= 1'b0;
      s1_pc_r    <= 32'd0;
      s2_valid_r <= 1'b0;
      s2_pc_r    <= 32'd0;
    end else if (bus.redirect_valid) begin
      pc_r       <= redirect_target_s;
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= issue_s;
      s1_pc_r    <= pc_r;
      s2_valid_r <= s1_valid_r;
      s2_pc_r    <= s1_pc_r;
      if (issue_s) begin
        pc_r <= pc_r + 32'd4;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  // Instruction FIFO: enqueue responses, dequeue on handshake, flush on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_r[i] <= {DATA_WIDTH{1'b0}};
        fifo_pc_r[i]    <= 32'd0;
        fifo_fault_r[i] <= 1'b0;
      end
    end else if (bus.redirect_valid) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_instr_r[wr_ptr_r] <= push_instr_s;
        fifo_pc_r[wr_ptr_r]    <= s2_pc_r;
        fifo_fault_r[wr_ptr_r] <= push_fault_s;
        wr_ptr_r               <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_stall_r;

  // Free-running event counters; survive redirects, wrap at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_r <= 32'd0;
      perf_stall_r   <= 32'd0;
    end else begin
      if (pop_s) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end else begin
        perf_fetched_r <= perf_fetched_r;
      end
      if (if_valid_s && !bus.id_ready) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_stall   = perf_stall_r;
`else
  assign perf_fetched = 32'd0;
  assign perf_stall   = 32'd0;
`endif

endmodule
